// File: rtl/cellnet_arbiter_pkg.sv
// Shared constants, state encoding and payload type for the cellnet round-robin arbiter.
package cellnet_arbiter_pkg;

    localparam int unsigned ADDRESS_SIZE = 8;
    localparam int unsigned DATA_SIZE    = 8;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    // Fixed encodings so external harnesses can match on the raw state value
    localparam logic [1:0] ARB_STATE_IDLE = 2'd0;
    localparam logic [1:0] ARB_STATE_FWD  = 2'd1;
    localparam logic [1:0] ARB_STATE_HOLD = 2'd2;
    localparam logic [1:0] ARB_STATE_REL  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = ARB_STATE_IDLE,
        ST_FWD  = ARB_STATE_FWD,
        ST_HOLD = ARB_STATE_HOLD,
        ST_REL  = ARB_STATE_REL
    } arb_state_t;

    typedef struct packed {
        logic [ADDRESS_SIZE-1:0] addr;
        logic [DATA_SIZE-1:0]    dat;
    } cell_t;

endpackage

// File: rtl/cellnet_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first requester after `last`, with wrap-around.
module cellnet_arbiter_rr_pick #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned GRANT_W = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [GRANT_W-1:0] last,
    output logic               valid,
    output logic [GRANT_W-1:0] idx
);

    // Scan farthest-first so the nearest requester after `last` is written last and wins
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            int cand;
            cand = (int'(last) + i) % int'(NUM_SRC);
            if (req[cand[GRANT_W-1:0]]) begin
                valid = 1'b1;
                idx   = cand[GRANT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/cellnet_arbiter.sv
// Shares one cellnet sink among NUM_SRC four-phase req/ack sources with round-robin fairness.
module cellnet_arbiter
    import cellnet_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned GRANT_W = $clog2(NUM_SRC)
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [NUM_SRC-1:0]             i_src_req,
    input  logic [NUM_SRC*ADDRESS_SIZE-1:0] i_src_addr,
    input  logic [NUM_SRC*DATA_SIZE-1:0]   i_src_dat,
    output logic [NUM_SRC-1:0]             o_src_ack,
    output logic [ADDRESS_SIZE-1:0]        o_addr,
    output logic [DATA_SIZE-1:0]           o_dat,
    output logic                           o_req,
    input  logic                           i_ack,
    output logic [GRANT_W-1:0]             o_grant,
    output logic                           o_busy,
    output logic                           o_err
);

    arb_state_t         state_q, state_n;
    logic [GRANT_W-1:0] last_q, last_n;
    logic [GRANT_W-1:0] grant_q, grant_n;
    cell_t              cell_q, cell_n;
    logic               req_q, req_n;
    logic [NUM_SRC-1:0] ack_q, ack_n;
    logic               busy_q;
    logic               err_q, err_n;

    logic               pick_valid;
    logic [GRANT_W-1:0] pick_idx;
    cell_t              src_cells [NUM_SRC];

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
        assign src_cells[k].addr = i_src_addr[k*ADDRESS_SIZE +: ADDRESS_SIZE];
        assign src_cells[k].dat  = i_src_dat[k*DATA_SIZE +: DATA_SIZE];
    end

    cellnet_arbiter_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .GRANT_W (GRANT_W)
    ) u_rr_pick (
        .req   (i_src_req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next-state and next-output logic; every output is the registered copy of these
    always_comb begin
        state_n = state_q;
        last_n  = last_q;
        grant_n = grant_q;
        cell_n  = cell_q;
        req_n   = req_q;
        ack_n   = ack_q;
        err_n   = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_ack) err_n = ON;
                if (pick_valid) begin
                    grant_n = pick_idx;
                    cell_n  = src_cells[pick_idx];
                    req_n   = ON;
                    state_n = ST_FWD;
                end
            end
            ST_FWD: begin
                // Winner must hold req and payload steady until the sink acknowledges
                if (!i_src_req[grant_q] || (src_cells[grant_q] != cell_q)) err_n = ON;
                if (i_ack) begin
                    ack_n[grant_q] = ON;
                    state_n        = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!i_src_req[grant_q]) begin
                    req_n   = OFF;
                    state_n = ST_REL;
                end
            end
            ST_REL: begin
                if (!i_ack) begin
                    ack_n   = '0;
                    last_n  = grant_q;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            last_q  <= GRANT_W'(NUM_SRC - 1);
            grant_q <= '0;
            cell_q  <= '0;
            req_q   <= OFF;
            ack_q   <= '0;
            busy_q  <= OFF;
            err_q   <= OFF;
        end else begin
            state_q <= state_n;
            last_q  <= last_n;
            grant_q <= grant_n;
            cell_q  <= cell_n;
            req_q   <= req_n;
            ack_q   <= ack_n;
            busy_q  <= (state_n != ST_IDLE);
            err_q   <= err_n;
        end
    end

    assign o_src_ack = ack_q;
    assign o_addr    = cell_q.addr;
    assign o_dat     = cell_q.dat;
    assign o_req     = req_q;
    assign o_grant   = grant_q;
    assign o_busy    = busy_q;
    assign o_err     = err_q;

endmodule
